mux_nway_arb: RTL

MUX_NWAY_ARB -- requirements
Module: mux_nway_arb

---
 rtl/mux_nway_arb.sv | 118 +++++++++++
 1 files changed

// File: rtl/mux_nway_arb.sv
// rtl/mux_nway_arb.sv - N-way channel mux with fixed-select or round-robin grant into a one-word output register.
module mux_nway_arb #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [SEL_W:0] CHAN_LIM = (SEL_W+1)'(CHANNELS);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             can_load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W:0]   cand;
    logic [SEL_W:0]   ptr_inc;
    logic [WIDTH-1:0] gnt_data;
    logic             gnt_in_valid;
    logic             transfer;

    assign can_load = !out_valid_q || out_ready;

    // Round-robin search walks upward from rr_ptr and wraps at CHANNELS, not at 2**SEL_W.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
            if (cand >= CHAN_LIM) begin
                cand = cand - CHAN_LIM;
            end
            if (!rr_found && in_valid[cand[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        if (mode) begin
            grant_valid = rr_found;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = ({1'b0, sel} < CHAN_LIM);
            grant_idx   = sel;
        end
    end

    always_comb begin
        gnt_data     = '0;
        gnt_in_valid = 1'b0;
        in_ready     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_valid && (grant_idx == SEL_W'(i))) begin
                gnt_data     = in_data[i*WIDTH +: WIDTH];
                gnt_in_valid = in_valid[i];
                in_ready[i]  = can_load && !reset;
            end
        end
    end

    assign transfer = grant_valid && gnt_in_valid && can_load && !reset;

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        ptr_inc     = {1'b0, grant_idx} + 1'b1;
        if (transfer) begin
            out_data_d  = gnt_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                rr_ptr_d = (ptr_inc == CHAN_LIM) ? '0 : ptr_inc[SEL_W-1:0];
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule
